serial_addsub_acc: RTL and testbench

- Parametrised, clocked bit-serial add/subtract unit; the sequential successor to the team's 4-input mapped adder/compare benchmarks.
- Processes one bit per cycle through a single full-adder cell (the XOR/majority cone those benchmarks realise) plus a carry flop.
- Optional accumulate mode feeds the previous result back as operand A.
- Sits as a standalone synthesis benchmark and as a low-area arithmetic leaf behind a start/done handshake.

---
 rtl/serial_addsub_acc_if.sv | 26 ++
 rtl/serial_addsub_acc.sv | 93 +++++++++
 tb/tb_serial_addsub_acc.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_acc_if.sv
// Operand/result bundle for the bit-serial add/subtract unit.
// The master issues operations; the slave is the arithmetic leaf.
interface serial_addsub_acc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, acc, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, acc, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_acc.sv
// Bit-serial add/subtract unit: one full-adder cell plus a carry flop, LSB first.
// In accumulate mode the previous result replaces operand A.
module serial_addsub_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  serial_addsub_acc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;

  assign bit_s    = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign bit_c    = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
  // Results are published on the edge entering DONE so sum/cout/ovf appear with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_a_q  <= bus.acc ? sum_q : bus.a;
            op_b_q  <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          res_q   <= {bit_s, res_q[WIDTH-1:1]};
          carry_q <= bit_c;
          cnt_q   <= cnt_q + 1'b1;
          // On the MSB cycle carry_q is the carry into the MSB, bit_c the carry out.
          if (last_bit) begin
            sum_q  <= {bit_s, res_q[WIDTH-1:1]};
            cout_q <= bit_c;
            ovf_q  <= carry_q ^ bit_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_acc.sv
// Self-checking bench for serial_addsub_acc: directed vector table at WIDTH=8,
// hand-written abort/ignored-start sequences, and random sweeps at WIDTH=2, 5, 32.
module tb_serial_addsub_acc;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_sweep_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  serial_addsub_acc_if #(.WIDTH(W)) sif ();
  serial_addsub_acc #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  typedef struct {
    logic         sub;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference: plain integer arithmetic on the operands, signed overflow from range.
  function automatic void model_op(input int w, input logic sub, input logic [63:0] opa,
                                   input logic [63:0] opb, output logic [63:0] s,
                                   output logic c, output logic o);
    logic [63:0] mask;
    logic [63:0] full;
    longint      sa, sb, sr, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    full = sub ? (opa - opb) : (opa + opb);
    s    = full & mask;
    c    = sub ? (opa >= opb) : full[w];
    sa   = opa[w-1] ? longint'(opa) - (longint'(1) << w) : longint'(opa);
    sb   = opb[w-1] ? longint'(opb) - (longint'(1) << w) : longint'(opb);
    sr   = sub ? (sa - sb) : (sa + sb);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    o    = (sr > smax) || (sr < smin);
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts cycles after the start edge.
  task automatic applyStimulus(input logic sub, input logic acc, input logic [W-1:0] a,
                               input logic [W-1:0] b, output int lat, output int busy_cycles);
    @(negedge clk);
    sif.sub   = sub;
    sif.acc   = acc;
    sif.a     = a;
    sif.b     = b;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start   = 1'b0;
    sif.a       = W'($urandom());
    sif.b       = W'($urandom());
    sif.sub     = 1'($urandom_range(0, 1));
    sif.acc     = 1'($urandom_range(0, 1));
    lat         = 1;
    busy_cycles = int'(sif.busy);
    while (!sif.done && lat < 100) begin
      @(negedge clk);
      lat++;
      busy_cycles += int'(sif.busy);
    end
  endtask

  initial begin
    rst_sweep_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_sweep_n = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int WS = (g == 0) ? 2 : ((g == 1) ? 5 : 32);
    bit finished = 1'b0;

    serial_addsub_acc_if #(.WIDTH(WS)) ssif ();
    serial_addsub_acc #(.WIDTH(WS), .CNT_W($clog2(WS + 1))) sdut (
      .clk   (clk),
      .rst_n (rst_sweep_n),
      .bus   (ssif)
    );

    initial begin
      logic [63:0]   model_sum;
      logic [63:0]   opa;
      logic [63:0]   es;
      logic          ec, eo;
      logic          s_sub, s_acc;
      logic [WS-1:0] av, bv, smax;
      int            lat;
      model_sum  = '0;
      smax       = {1'b0, {(WS-1){1'b1}}};
      ssif.start = 1'b0;
      ssif.sub   = 1'b0;
      ssif.acc   = 1'b0;
      ssif.a     = '0;
      ssif.b     = '0;
      repeat (5) @(negedge clk);
      checkOutput($sformatf("w%0d reset sum", WS), 64'(ssif.sum), 64'd0);
      for (int k = 0; k < 40; k++) begin
        s_acc = ($urandom_range(0, 3) == 0);
        s_sub = 1'($urandom_range(0, 1));
        av    = WS'($urandom());
        bv    = WS'($urandom());
        case (k)
          0: begin av = '1;    bv = WS'(1); s_sub = 1'b0; s_acc = 1'b0; end
          1: begin av = smax;  bv = WS'(1); s_sub = 1'b0; s_acc = 1'b0; end
          2: begin av = ~smax; bv = WS'(1); s_sub = 1'b1; s_acc = 1'b0; end
          3: begin av = '0;    bv = '0;     s_sub = 1'b1; s_acc = 1'b0; end
          default: ;
        endcase
        @(negedge clk);
        ssif.sub   = s_sub;
        ssif.acc   = s_acc;
        ssif.a     = av;
        ssif.b     = bv;
        ssif.start = 1'b1;
        @(negedge clk);
        ssif.start = 1'b0;
        ssif.a     = WS'($urandom());
        lat        = 1;
        while (!ssif.done && lat < 100) begin
          @(negedge clk);
          lat++;
        end
        opa = s_acc ? model_sum : 64'(av);
        model_op(WS, s_sub, opa, 64'(bv), es, ec, eo);
        model_sum = es;
        checkOutput($sformatf("w%0d op%0d sum", WS, k), 64'(ssif.sum), es);
        checkOutput($sformatf("w%0d op%0d cout", WS, k), 64'(ssif.cout), 64'(ec));
        checkOutput($sformatf("w%0d op%0d ovf", WS, k), 64'(ssif.ovf), 64'(eo));
        checkOutput($sformatf("w%0d op%0d latency", WS, k), 64'(lat), 64'(WS + 1));
      end
      finished = 1'b1;
    end
  end

  initial begin
    vec_t vecs[9];
    int   lat, busy_cycles, done_cnt, waited;

    // acc rows chain from the previous row's result; 'a' there must be ignored.
    vecs[0] = '{1'b0, 1'b0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hAA, 8'h10, 8'h61, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 8'h7F, 8'h81, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h80, 8'h01, 1'b1, 1'b1};

    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.sub   = 1'b0;
    sif.acc   = 1'b0;
    sif.a     = 8'h3C;
    sif.b     = 8'h15;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sif.start = ~sif.start;
      checkOutput($sformatf("reset%0d busy", i), 64'(sif.busy), 64'd0);
      checkOutput($sformatf("reset%0d done", i), 64'(sif.done), 64'd0);
      checkOutput($sformatf("reset%0d sum", i), 64'(sif.sum), 64'd0);
      checkOutput($sformatf("reset%0d cout", i), 64'(sif.cout), 64'd0);
      checkOutput($sformatf("reset%0d ovf", i), 64'(sif.ovf), 64'd0);
    end
    @(negedge clk);
    sif.start = 1'b0;
    rst_n     = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].sub, vecs[i].acc, vecs[i].a, vecs[i].b, lat, busy_cycles);
      checkOutput($sformatf("vec%0d sum", i), 64'(sif.sum), 64'(vecs[i].exp_sum));
      checkOutput($sformatf("vec%0d cout", i), 64'(sif.cout), 64'(vecs[i].exp_cout));
      checkOutput($sformatf("vec%0d ovf", i), 64'(sif.ovf), 64'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(W + 1));
      checkOutput($sformatf("vec%0d busy cycles", i), 64'(busy_cycles), 64'(W + 1));
      @(negedge clk);
      checkOutput($sformatf("vec%0d done pulse width", i), 64'(sif.done), 64'd0);
    end

    // A start raised mid-RUN must be neither honoured nor queued.
    @(negedge clk);
    sif.sub = 1'b0; sif.acc = 1'b0; sif.a = 8'h11; sif.b = 8'h22; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    done_cnt  = 0;
    repeat (2) @(negedge clk);
    sif.sub = 1'b1; sif.a = 8'hFF; sif.b = 8'h0F; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      done_cnt += int'(sif.done);
    end
    checkOutput("ignored start done count", 64'(done_cnt), 64'd1);
    checkOutput("ignored start sum", 64'(sif.sum), 64'h33);
    checkOutput("ignored start idle", 64'(sif.busy), 64'd0);

    // Reset during RUN cycle 4 aborts without a done pulse.
    @(negedge clk);
    sif.sub = 1'b0; sif.acc = 1'b0; sif.a = 8'h10; sif.b = 8'h20; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort sum", 64'(sif.sum), 64'd0);
    checkOutput("abort busy", 64'(sif.busy), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      done_cnt += int'(sif.done);
    end
    checkOutput("abort done count", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h12, 8'h34, lat, busy_cycles);
    checkOutput("post-abort sum", 64'(sif.sum), 64'h46);
    checkOutput("post-abort latency", 64'(lat), 64'(W + 1));

    waited = 0;
    while (!(g_sweep[0].finished && g_sweep[1].finished && g_sweep[2].finished) && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("sweeps finished", 64'(g_sweep[0].finished && g_sweep[1].finished && g_sweep[2].finished), 64'd1);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
